// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch run control: prescaled tick, start/stop/clear FSM, BCD decade cascade with overflow.
// Optional display hold (lap) is built only when LAP_HOLD_EN is defined.
module bcd_stopwatch_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   digits_o,
  output logic                  tick_o,
  output logic                  ovf_o,
  output logic [1:0]            state_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t                state_q;
  logic [PW-1:0]         pre_q;
  logic [4*DIGITS-1:0]   live_q;
  logic [4*DIGITS-1:0]   live_d;
  logic                  tick_q;
  logic                  ovf_q;
  logic [DIGITS:0]       carry;
  logic                  all_nines;
  logic                  wrap;

  // carry[k] is set when every digit below k holds 9
  always_comb begin
    carry[0] = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      carry[k+1] = carry[k] & (live_q[4*k +: 4] == 4'd9);
    end
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign live_d[4*gi +: 4] = !carry[gi]                     ? live_q[4*gi +: 4] :
                                 (live_q[4*gi +: 4] == 4'd9)    ? 4'd0 :
                                                                  live_q[4*gi +: 4] + 4'd1;
    end
  endgenerate

  assign all_nines = carry[DIGITS];
  assign wrap      = (pre_q == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      live_q  <= '0;
      tick_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (clear) begin
        state_q <= S_IDLE;
        pre_q   <= '0;
        live_q  <= '0;
        ovf_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE:  if (start) state_q <= S_RUN;
          S_RUN: begin
            if (stop) begin
              state_q <= S_PAUSE;
            end else if (wrap) begin
              pre_q  <= '0;
              tick_q <= 1'b1;
              // full scale: hold all nines rather than wrapping
              if (all_nines) begin
                ovf_q   <= 1'b1;
                state_q <= S_DONE;
              end else begin
                live_q <= live_d;
              end
            end else begin
              pre_q <= pre_q + 1'b1;
            end
          end
          S_PAUSE: if (start) state_q <= S_RUN;
          default: ;
        endcase
      end
    end
  end

  assign tick_o  = tick_q;
  assign ovf_o   = ovf_q;
  assign state_o = state_q;

`ifdef LAP_HOLD_EN
  logic                hold_q;
  logic [4*DIGITS-1:0] shadow_q;
  logic                enter_done;

  assign enter_done = (state_q == S_RUN) && !stop && wrap && all_nines;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q   <= 1'b0;
      shadow_q <= '0;
    end else if (clear || enter_done) begin
      hold_q <= 1'b0;
    end else if (lap && (state_q == S_RUN || state_q == S_PAUSE)) begin
      hold_q <= !hold_q;
      if (!hold_q) shadow_q <= live_q;
    end
  end

  assign digits_o = hold_q ? shadow_q : live_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign digits_o   = live_q;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Scoreboard bench for bcd_stopwatch_ctrl: two instances (PRESCALE=10 and PRESCALE=1) share stimulus;
// a behavioural model pushes expected outputs each cycle, compared after the clock edge.
module tb_bcd_stopwatch_ctrl;

  localparam int MAXC = 9999;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [15:0] dig0, dig1;
  logic        tick0, tick1, ovf0, ovf1;
  logic [1:0]  st0, st1;

  always #5 clk = ~clk;

  bcd_stopwatch_ctrl #(.DIGITS(4), .PRESCALE(10)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .digits_o(dig0), .tick_o(tick0), .ovf_o(ovf0), .state_o(st0)
  );

  bcd_stopwatch_ctrl #(.DIGITS(4), .PRESCALE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .digits_o(dig1), .tick_o(tick1), .ovf_o(ovf1), .state_o(st1)
  );

  typedef struct packed {
    logic [15:0] dig;
    logic        tick;
    logic        ovf;
    logic [1:0]  st;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   n_tick0 = 0;
  int   last_tick0 = -1;
  bit   gap_en = 1'b0;

  int   m_state[2];
  int   m_pre[2];
  int   m_cnt[2];
  int   m_shadow[2];
  bit   m_ovf[2];
  bit   m_tick[2];
  bit   m_hold[2];

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          d;
    r = '0;
    d = v;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return r;
  endfunction

  // Behavioural reference: integer count, converted to BCD only for comparison
  task automatic model_step();
    exp_t e;
    int   ps;
    int   old_st;
    int   old_cnt;
    for (int i = 0; i < 2; i++) begin
      ps      = (i == 0) ? 10 : 1;
      old_st  = m_state[i];
      old_cnt = m_cnt[i];
      m_tick[i] = 1'b0;
      if (rst) begin
        m_state[i] = 0; m_pre[i] = 0; m_cnt[i] = 0; m_ovf[i] = 1'b0; m_hold[i] = 1'b0;
      end else if (clear) begin
        m_state[i] = 0; m_pre[i] = 0; m_cnt[i] = 0; m_ovf[i] = 1'b0; m_hold[i] = 1'b0;
      end else begin
`ifdef LAP_HOLD_EN
        if (lap && (old_st == 1 || old_st == 2)) begin
          if (m_hold[i]) m_hold[i] = 1'b0;
          else begin
            m_hold[i]   = 1'b1;
            m_shadow[i] = old_cnt;
          end
        end
`endif
        case (old_st)
          0: if (start) m_state[i] = 1;
          1: begin
            if (stop) m_state[i] = 2;
            else if (m_pre[i] == ps - 1) begin
              m_pre[i]  = 0;
              m_tick[i] = 1'b1;
              if (m_cnt[i] == MAXC) begin
                m_ovf[i]   = 1'b1;
                m_state[i] = 3;
                m_hold[i]  = 1'b0;
              end else begin
                m_cnt[i] = m_cnt[i] + 1;
              end
            end else begin
              m_pre[i] = m_pre[i] + 1;
            end
          end
          2: if (start) m_state[i] = 1;
          default: ;
        endcase
      end
      e.dig  = to_bcd(m_hold[i] ? m_shadow[i] : m_cnt[i]);
      e.tick = m_tick[i];
      e.ovf  = m_ovf[i];
      e.st   = 2'(m_state[i]);
      sb_q.push_back(e);
    end
  endtask

  task automatic cycle();
    exp_t e0, e1;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    e0 = sb_q.pop_front();
    e1 = sb_q.pop_front();
    check_val("i0_digits", dig0, e0.dig);
    check_val("i0_tick", tick0, e0.tick);
    check_val("i0_ovf", ovf0, e0.ovf);
    check_val("i0_state", st0, e0.st);
    check_val("i1_digits", dig1, e1.dig);
    check_val("i1_tick", tick1, e1.tick);
    check_val("i1_ovf", ovf1, e1.ovf);
    check_val("i1_state", st1, e1.st);
    if (tick0) begin
      n_tick0++;
      if (gap_en && last_tick0 >= 0) check_val("i0_tick_gap", cyc - last_tick0, 10);
      last_tick0 = cyc;
    end
  endtask

  task automatic pulse(input logic s, input logic sp, input logic cl, input logic lp);
    start = s; stop = sp; clear = cl; lap = lp;
    cycle();
    start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    #1;
    check_val("rst_digits", dig0, 16'h0000);
    check_val("rst_state", st0, 2'b00);
    check_val("rst_ovf", ovf0, 1'b0);
    check_val("rst_tick", tick0, 1'b0);
    cycle();
    cycle();
    rst = 1'b0;
    $display("txn reset: initial values checked");

    // basic run: 100 cycles gives ten evenly spaced ticks
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    n_tick0 = 0; last_tick0 = -1; gap_en = 1'b1;
    idle(100);
    gap_en = 1'b0;
    check_val("basic_digits", dig0, 16'h0010);
    check_val("basic_ticks", n_tick0, 10);
    $display("txn basic run: digits=%h ticks=%0d", dig0, n_tick0);

    // pause with prescaler at 4, resume needs the remaining six RUN cycles
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    idle(354);
    check_val("pause_pre", dig0, 16'h0035);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    idle(50);
    check_val("pause_hold", dig0, 16'h0035);
    check_val("pause_state", st0, 2'b10);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    check_val("resume_early", dig0, 16'h0035);
    idle(1);
    check_val("resume_digits", dig0, 16'h0036);
    check_val("resume_tick", tick0, 1'b1);
    $display("txn pause/resume: digits=%h", dig0);

    // asynchronous reset mid-run
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    idle(420);
    check_val("pre_rst_digits", dig0, 16'h0042);
    rst = 1'b1;
    #2;
    check_val("async_rst_digits", dig0, 16'h0000);
    check_val("async_rst_state", st0, 2'b00);
    check_val("async_rst_ovf", ovf0, 1'b0);
    check_val("async_rst_tick", tick0, 1'b0);
    cycle();
    rst = 1'b0;
    idle(20);
    check_val("post_rst_digits", dig0, 16'h0000);
    check_val("post_rst_state", st0, 2'b00);
    $display("txn async reset: digits=%h state=%b", dig0, st0);

    // carry chain on instance 0, overflow on instance 1
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    idle(990);
    check_val("carry_0099", dig0, 16'h0099);
    idle(10);
    check_val("carry_0100", dig0, 16'h0100);
    idle(8990);
    check_val("carry_0999", dig0, 16'h0999);
    check_val("ovf_not_yet", ovf1, 1'b0);
    idle(10);
    check_val("carry_1000", dig0, 16'h1000);
    check_val("ovf_digits", dig1, 16'h9999);
    check_val("ovf_flag", ovf1, 1'b1);
    check_val("ovf_state", st1, 2'b11);
    check_val("ovf_tick", tick1, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_val("done_start_ign", st1, 2'b11);
    check_val("done_digits", dig1, 16'h9999);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("ovf_clr_digits", dig1, 16'h0000);
    check_val("ovf_clr_flag", ovf1, 1'b0);
    check_val("ovf_clr_state", st1, 2'b00);
    $display("txn carry/overflow: i0=%h i1=%h", dig0, dig1);

    // simultaneous commands
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    check_val("clr_start_state", st0, 2'b00);
    check_val("clr_start_digits", dig0, 16'h0000);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("stop_start_state", st0, 2'b10);
    $display("txn simultaneous: state=%b", st0);

    // lap hold (ignored when the feature is not built)
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    idle(120);
    check_val("lap_pre", dig0, 16'h0012);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    idle(79);
`ifdef LAP_HOLD_EN
    check_val("lap_frozen", dig0, 16'h0012);
`else
    check_val("lap_ignored", dig0, 16'h0020);
`endif
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("lap_release", dig0, 16'h0020);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    idle(10);
    check_val("lap_idle_ign", dig0, 16'h0001);
    $display("txn lap: digits=%h", dig0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
